matrix_uart_sequencer: RTL and testbench
========================================

# matrix_uart_sequencer

Parametrised NxN matrix-multiply sequencer that sits between the UART receiver/transmitter and on-chip storage. It accepts a size byte, then matrices A and B as byte streams, and computes C = A·B with one multiply-accumulate per cycle. It returns C over the UART transmit handshake as multi-byte results. It supersedes the fixed 3x3 top-level datapath and adds runtime size selection, a signed mode, result widening, error signalling and overrun detection.

## Interface
- MAX_N, 4: largest accepted matrix dimension (1..8).
- SIGNED, 0: 0 = unsigned elements; 1 = two's-complement elements.
- ACC_W (derived, not overridable): 17 + clog2(MAX_N); accumulator width.
- RES_BYTES (derived): ceil(ACC_W/8); bytes sent per result element.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte; valid only while rx_valid is high.
- rx_valid  in  1  single-cycle strobe, one per received byte.
- tx_busy  in  1  transmitter busy.
- tx_data  out  8  byte to transmit; held stable from tx_start until tx_busy falls.
- tx_start  out  1  single-cycle transmit request.
- state  out  3  current FSM state code.
- err  out  1  sticky; size byte was invalid.
- overrun  out  1  sticky; a byte arrived while it could not be accepted.

## Operation
- State codes: IDLE=0, LOAD_A=1, LOAD_B=2, COMPUTE=3, SEND=4, SEND_WAIT=5, ERROR=6.
- **IDLE**: on rx_valid, latch the byte as N.
  - 1 ≤ N ≤ MAX_N: clear err and overrun, zero the element counter, go to LOAD_A.
  - Otherwise (including 0): set err, go to ERROR.
- **LOAD_A / LOAD_B**: each rx_valid writes one byte row-major into the A (then B) array at index counter = r·N + c.
  - After byte N²−1 the counter clears and the FSM advances: LOAD_A → LOAD_B, LOAD_B → COMPUTE.
- **COMPUTE**: nested loops i, j, k over 0..N−1, k innermost, one MAC per cycle.
  - acc ← (k==0 ? 0 : acc) + A[i][k]·B[k][j].
  - Operands are sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to ACC_W before multiplying.
  - At k = N−1 the final sum is written to C[i][j].
  - Exactly N³ cycles in COMPUTE; then go to SEND with the result counter and byte counter at 0.
- **SEND**: when tx_busy is low, drive tx_data with byte b of C[e] and pulse tx_start; go to SEND_WAIT.
  - C[e] is extended to RES_BYTES·8 bits (sign-extended when SIGNED=1), sent LSB first.
  - Elements are sent in row-major order.
- **SEND_WAIT**: wait until tx_busy has been seen high and then low.
  - Advance b; after byte RES_BYTES−1, advance e.
  - After the last byte of C[N²−1], go to IDLE. Otherwise return to SEND.
- **ERROR**: send the single byte 0xEE using the same SEND/SEND_WAIT handshake, then go to IDLE. err stays set.
- **Overrun**: rx_valid in COMPUTE, SEND, SEND_WAIT or ERROR sets overrun. The byte is discarded and the state is unaffected.
- **Storage**: A and B are MAX_N² bytes each; C is MAX_N² × ACC_W. Storage contents are not cleared by reset.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, tx_start=0, tx_data=0x00, err=0, overrun=0.
  - All counters cleared; N=0.
- Reset mid-operation abandons the transfer. The next byte after reset deassertion is treated as a size byte.
- rx_valid to storage write: 1 cycle. The state advance happens in the same cycle as the final byte write.
- COMPUTE entry to SEND entry: N³ cycles.
- tx_start:
  - Never asserted in consecutive cycles.
  - Never asserted while tx_busy is high.
  - First tx_start comes 1 cycle after SEND entry if tx_busy is low.
- rx_valid and tx_busy edges in the same cycle are handled independently.
- Total bytes transmitted per job: N²·RES_BYTES, or exactly 1 on error.

## Test plan
- **2x2 unsigned** (MAX_N=4, RES_BYTES=3)
  - Stimulus: size 0x02, A=[1,2,3,4], B=[5,6,7,8].
  - Required: tx bytes 13,00,00, 16,00,00, 2B,00,00, 32,00,00 (19,22,43,50); err=0.
- **Width corner**
  - Stimulus: size 0x04, all 32 A/B bytes 0xFF.
  - Required: 16 results each 04,F8,03 (260100); COMPUTE lasts exactly 64 cycles.
- **Signed mode** (SIGNED=1)
  - Stimulus: size 0x01, A=0xFF, B=0x02.
  - Required: bytes FE,FF,FF (−2).
- **Invalid size**
  - Stimulus: size 0x00, then separately size 0x05.
  - Required: each sends exactly one byte 0xEE; err=1; state returns to 0.
- **Overrun**
  - Stimulus: inject rx_valid during COMPUTE of a 3x3 job.
  - Required: overrun=1, results unchanged; overrun clears on the next valid size byte.
- **Reset mid-LOAD_B**
  - Stimulus: assert rst after 2 B bytes.
  - Required: outputs at reset values immediately; a following 1x1 job (size 01, A=03, B=04) returns 0C,00,00.

Source files
------------

// File: rtl/matrix_uart_sequencer.sv
// NxN matrix-multiply sequencer between a UART byte stream and local storage.
// Loads size, A and B, computes C = A*B with one MAC per cycle, streams C back LSB first.
module matrix_uart_sequencer #(
    parameter int MAX_N  = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic [2:0] state,
    output logic       err,
    output logic       overrun
);
    localparam int ACC_W     = 17 + $clog2(MAX_N);
    localparam int RES_BYTES = (ACC_W + 7) / 8;
    localparam int ELEMS     = MAX_N * MAX_N;
    localparam int IDX_W     = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam int DIM_W     = $clog2(MAX_N + 1);
    localparam int NN_W      = 2 * DIM_W;
    localparam int BYTE_W    = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_A    = 3'd1,
        LOAD_B    = 3'd2,
        COMPUTE   = 3'd3,
        SEND      = 3'd4,
        SEND_WAIT = 3'd5,
        ERROR     = 3'd6
    } state_t;

    state_t st, st_nxt;

    logic [DIM_W-1:0]  n, i, j, k;
    logic [IDX_W-1:0]  cnt, e;
    logic [BYTE_W-1:0] b;
    logic [ACC_W-1:0]  acc;
    logic              seen_busy;
    logic              err_job;

    logic [7:0]       a_mem [ELEMS];
    logic [7:0]       b_mem [ELEMS];
    logic [ACC_W-1:0] c_mem [ELEMS];

    logic [DIM_W-1:0]              n_m1;
    logic [NN_W-1:0]               nn;
    logic [IDX_W-1:0]              last_idx, a_idx, b_idx, c_idx;
    logic [ACC_W-1:0]              prod, sum;
    logic [RES_BYTES-1:0][7:0]     c_bytes;
    logic                          size_ok, last_byte, mac_last;

    function automatic logic [ACC_W-1:0] ext8(input logic [7:0] x);
        if (SIGNED) return ACC_W'($signed(x));
        else        return ACC_W'(x);
    endfunction

    assign state     = st;
    assign n_m1      = n - 1'b1;
    assign nn        = NN_W'(n) * NN_W'(n);
    assign last_idx  = IDX_W'(nn - NN_W'(1));
    assign a_idx     = IDX_W'(NN_W'(i) * NN_W'(n) + NN_W'(k));
    assign b_idx     = IDX_W'(NN_W'(k) * NN_W'(n) + NN_W'(j));
    assign c_idx     = IDX_W'(NN_W'(i) * NN_W'(n) + NN_W'(j));
    assign prod      = ext8(a_mem[a_idx]) * ext8(b_mem[b_idx]);
    assign sum       = ((k == '0) ? '0 : acc) + prod;
    assign size_ok   = (rx_data != 8'd0) && (rx_data <= 8'(MAX_N));
    assign last_byte = (b == BYTE_W'(RES_BYTES - 1));
    assign mac_last  = (i == n_m1) && (j == n_m1) && (k == n_m1);

    always_comb begin
        if (SIGNED) c_bytes = (RES_BYTES * 8)'($signed(c_mem[e]));
        else        c_bytes = (RES_BYTES * 8)'(c_mem[e]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= IDLE;
        else     st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            IDLE:      if (rx_valid) st_nxt = size_ok ? LOAD_A : ERROR;
            LOAD_A:    if (rx_valid && cnt == last_idx) st_nxt = LOAD_B;
            LOAD_B:    if (rx_valid && cnt == last_idx) st_nxt = COMPUTE;
            COMPUTE:   if (mac_last) st_nxt = SEND;
            SEND,
            ERROR:     if (!tx_busy) st_nxt = SEND_WAIT;
            SEND_WAIT: if (seen_busy && !tx_busy) begin
                           if (err_job || (e == last_idx && last_byte)) st_nxt = IDLE;
                           else                                         st_nxt = SEND;
                       end
            default:   st_nxt = IDLE;
        endcase
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (st == LOAD_A && rx_valid) a_mem[cnt] <= rx_data;
        if (st == LOAD_B && rx_valid) b_mem[cnt] <= rx_data;
        if (st == COMPUTE && k == n_m1) c_mem[c_idx] <= sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data   <= 8'h00;
            tx_start  <= 1'b0;
            err       <= 1'b0;
            overrun   <= 1'b0;
            n         <= '0;
            cnt       <= '0;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            acc       <= '0;
            e         <= '0;
            b         <= '0;
            seen_busy <= 1'b0;
            err_job   <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (st)
                IDLE: if (rx_valid) begin
                    n <= rx_data[DIM_W-1:0];
                    if (size_ok) begin
                        err     <= 1'b0;
                        overrun <= 1'b0;
                        err_job <= 1'b0;
                        cnt     <= '0;
                        i       <= '0;
                        j       <= '0;
                        k       <= '0;
                        e       <= '0;
                        b       <= '0;
                    end else begin
                        err     <= 1'b1;
                        err_job <= 1'b1;
                    end
                end
                LOAD_A, LOAD_B: if (rx_valid) cnt <= (cnt == last_idx) ? '0 : cnt + 1'b1;
                COMPUTE: begin
                    acc <= sum;
                    if (k == n_m1) begin
                        k <= '0;
                        if (j == n_m1) begin
                            j <= '0;
                            i <= (i == n_m1) ? '0 : i + 1'b1;
                        end else begin
                            j <= j + 1'b1;
                        end
                    end else begin
                        k <= k + 1'b1;
                    end
                    if (mac_last) begin
                        e <= '0;
                        b <= '0;
                    end
                end
                SEND: if (!tx_busy) begin
                    tx_data   <= c_bytes[b];
                    tx_start  <= 1'b1;
                    seen_busy <= 1'b0;
                end
                ERROR: if (!tx_busy) begin
                    tx_data   <= 8'hEE;
                    tx_start  <= 1'b1;
                    seen_busy <= 1'b0;
                end
                SEND_WAIT: begin
                    // A byte is done only after busy has been observed high then low.
                    if (tx_busy) begin
                        seen_busy <= 1'b1;
                    end else if (seen_busy) begin
                        if (last_byte) begin
                            b <= '0;
                            e <= e + 1'b1;
                        end else begin
                            b <= b + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            if (rx_valid && (st == COMPUTE || st == SEND || st == SEND_WAIT || st == ERROR))
                overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_matrix_uart_sequencer.sv
// Scoreboard bench: an unsigned and a signed sequencer share the rx stream; a monitor
// with a simple transmitter model pops expected bytes computed from plain matrix arithmetic.
module tb_matrix_uart_sequencer;
    localparam int MAX_N     = 4;
    localparam int RES_BYTES = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [1:0] tx_busy = 2'b00;
    logic [7:0] tx_data [2];
    logic [1:0] tx_start, err, overrun;
    logic [2:0] state [2];

    int compares = 0;
    int mism = 0;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    logic [7:0] ma [16];
    logic [7:0] mb [16];
    int busy_cnt [2];
    logic [7:0] held [2];
    logic [1:0] prev_start = 2'b00;
    int comp_run = 0;
    int comp_len = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        matrix_uart_sequencer #(.MAX_N(MAX_N), .SIGNED(g == 1)) dut (
            .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
            .tx_busy(tx_busy[g]), .tx_data(tx_data[g]), .tx_start(tx_start[g]),
            .state(state[g]), .err(err[g]), .overrun(overrun[g]));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compares++;
        if (act !== exp) begin
            mism++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Transmitter model and scoreboard consumer.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (tx_start[g]) begin
                chk($sformatf("dut%0d start_while_busy", g), 32'(tx_busy[g]), 0);
                chk($sformatf("dut%0d start_back_to_back", g), 32'(prev_start[g]), 0);
                if ((g == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                    compares++;
                    mism++;
                    $display("FAIL dut%0d unexpected_byte: got 0x%02h, expected none", g, tx_data[g]);
                end else if (g == 0) begin
                    chk("dut0 tx_byte", 32'(tx_data[g]), 32'(exp_q0.pop_front()));
                end else begin
                    chk("dut1 tx_byte", 32'(tx_data[g]), 32'(exp_q1.pop_front()));
                end
                held[g] = tx_data[g];
                tx_busy[g] = 1'b1;
                busy_cnt[g] = $urandom_range(1, 4);
            end else if (tx_busy[g]) begin
                chk($sformatf("dut%0d tx_data_hold", g), 32'(tx_data[g]), 32'(held[g]));
                busy_cnt[g]--;
                if (busy_cnt[g] == 0) tx_busy[g] = 1'b0;
            end
            prev_start[g] = tx_start[g];
        end
    end

    always @(negedge clk) begin
        if (state[0] == 3'd3) begin
            comp_run++;
        end else if (comp_run != 0) begin
            comp_len = comp_run;
            comp_run = 0;
        end
    end

    function automatic int elem(input logic [7:0] v, input int sgn);
        if (sgn != 0) return int'($signed(v));
        return int'(v);
    endfunction

    task automatic push_expected(input int n);
        for (int g = 0; g < 2; g++)
            for (int r = 0; r < n; r++)
                for (int c = 0; c < n; c++) begin
                    int sum;
                    sum = 0;
                    for (int x = 0; x < n; x++) sum += elem(ma[r*n+x], g) * elem(mb[x*n+c], g);
                    for (int bt = 0; bt < RES_BYTES; bt++) begin
                        if (g == 0) exp_q0.push_back(8'(sum >> (8*bt)));
                        else        exp_q1.push_back(8'(sum >> (8*bt)));
                    end
                end
    endtask

    task automatic send_byte(input logic [7:0] v);
        @(negedge clk);
        rx_data = v;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (!(state[0] == 3'd0 && state[1] == 3'd0 && exp_q0.size() == 0 &&
                 exp_q1.size() == 0 && tx_busy == 2'b00) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk({name, " completes"}, 32'(t < 5000), 1);
    endtask

    task automatic run_job(input int n, input bit inject, input string name);
        push_expected(n);
        send_byte(8'(n));
        for (int x = 0; x < n*n; x++) send_byte(ma[x]);
        for (int x = 0; x < n*n; x++) send_byte(mb[x]);
        if (inject) begin
            repeat (3) @(negedge clk);
            chk({name, " in_compute"}, 32'(state[0]), 3);
            send_byte(8'($urandom));
        end
        wait_done(name);
    endtask

    task automatic err_job(input logic [7:0] sz, input string name);
        exp_q0.push_back(8'hEE);
        exp_q1.push_back(8'hEE);
        send_byte(sz);
        wait_done(name);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("%s dut%0d err", name, g), 32'(err[g]), 1);
            chk($sformatf("%s dut%0d state", name, g), 32'(state[g]), 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("reset dut%0d state", g), 32'(state[g]), 0);
            chk($sformatf("reset dut%0d tx_start", g), 32'(tx_start[g]), 0);
            chk($sformatf("reset dut%0d tx_data", g), 32'(tx_data[g]), 0);
            chk($sformatf("reset dut%0d err", g), 32'(err[g]), 0);
            chk($sformatf("reset dut%0d overrun", g), 32'(overrun[g]), 0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int x = 0; x < 4; x++) begin ma[x] = 8'(x + 1); mb[x] = 8'(x + 5); end
        run_job(2, 0, "2x2");
        chk("2x2 err", 32'(err), 0);
        chk("2x2 compute_cycles", 32'(comp_len), 8);

        for (int x = 0; x < 16; x++) begin ma[x] = 8'hFF; mb[x] = 8'hFF; end
        run_job(4, 0, "width");
        chk("width compute_cycles", 32'(comp_len), 64);

        ma[0] = 8'hFF; mb[0] = 8'h02;
        run_job(1, 0, "signed1x1");
        chk("1x1 compute_cycles", 32'(comp_len), 1);

        err_job(8'h00, "size0");
        err_job(8'h05, "size5");

        for (int x = 0; x < 9; x++) begin ma[x] = 8'($urandom); mb[x] = 8'($urandom); end
        run_job(3, 1, "overrun3x3");
        chk("overrun flag", 32'(overrun), 3);
        chk("overrun err_cleared", 32'(err), 0);
        chk("3x3 compute_cycles", 32'(comp_len), 27);

        for (int x = 0; x < 4; x++) begin ma[x] = 8'($urandom); mb[x] = 8'($urandom); end
        run_job(2, 0, "after_overrun");
        chk("overrun cleared", 32'(overrun), 0);

        // Abandon a job part-way through B with an asynchronous reset.
        send_byte(8'h02);
        for (int x = 0; x < 4; x++) send_byte(8'($urandom));
        send_byte(8'h11);
        send_byte(8'h22);
        chk("pre_reset state", 32'(state[0]), 2);
        rst = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("midreset dut%0d state", g), 32'(state[g]), 0);
            chk($sformatf("midreset dut%0d tx_start", g), 32'(tx_start[g]), 0);
            chk($sformatf("midreset dut%0d tx_data", g), 32'(tx_data[g]), 0);
            chk($sformatf("midreset dut%0d err", g), 32'(err[g]), 0);
            chk($sformatf("midreset dut%0d overrun", g), 32'(overrun[g]), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        ma[0] = 8'h03; mb[0] = 8'h04;
        run_job(1, 0, "post_reset1x1");

        for (int t = 0; t < 8; t++) begin
            int n;
            n = $urandom_range(1, MAX_N);
            for (int x = 0; x < n*n; x++) begin ma[x] = 8'($urandom); mb[x] = 8'($urandom); end
            run_job(n, 0, $sformatf("random%0d", t));
            chk($sformatf("random%0d compute_cycles", t), 32'(comp_len), 32'(n*n*n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mism);
        $finish;
    end
endmodule
